eth_frame_former_v2: RTL and testbench
======================================

Name: eth_frame_former_v2

Overview:
Parametrised successor frame former. Accepts a raw AXI-Stream payload and emits a complete Ethernet II frame (no FCS): a 16-byte header followed by the payload. The header is Destination MAC, Source MAC, EtherType and a 16-bit SyncWord. Adds three things: a configurable bus width, optional zero-padding to the 60-byte minimum frame, and truncate-and-drop for oversize payloads. Sits between the payload producer and the MAC TX stream.

Parameters:
DATA_WIDTH, 64, stream width in bits; legal values 32, 64, 128; HDR_BEATS = 128/DATA_WIDTH.
MAX_PAYLOAD, 1498, maximum payload bytes per frame (excludes the 16 header bytes); range 1..16383.
MIN_FRAME, 60, minimum frame bytes including header when padding is enabled.

Ports:
ACLK  in  1  clock; all logic is on the rising edge.
ARESETN  in  1  asynchronous, active-low reset.
S_AXIS_tdata  in  DATA_WIDTH  payload bytes; byte 0 is in [7:0].
S_AXIS_tkeep  in  DATA_WIDTH/8  all ones except on tlast, where it is contiguous LSB ones.
S_AXIS_tvalid  in  1  payload valid.
S_AXIS_tlast  in  1  last payload beat.
S_AXIS_tready  out  1  payload ready.
M_AXIS_tdata  out  DATA_WIDTH  frame bytes; first wire byte is in [7:0].
M_AXIS_tkeep  out  DATA_WIDTH/8  byte enables.
M_AXIS_tvalid  out  1  frame beat valid.
M_AXIS_tlast  out  1  last frame beat.
M_AXIS_tready  in  1  downstream ready.
Destination_Address  in  48  destination MAC.
Source_Address  in  48  source MAC.
Link_Type  in  16  EtherType.
SyncWord  in  16  sync word placed after the EtherType.
Enable_Padding  in  1  1 = pad short frames to MIN_FRAME.
frame_count  out  16  frames completed; wraps at 65535→0.
oversize_pulse  out  1  one-cycle pulse on each truncation.
busy  out  1  high while state is not IDLE.

Behaviour:
- Reset values (asynchronous): state=IDLE; M_AXIS_tvalid=0, M_AXIS_tlast=0; M_AXIS_tdata=0, M_AXIS_tkeep=0; S_AXIS_tready=0; frame_count=0; oversize_pulse=0; busy=0; byte counter=0. Reset asserted mid-frame discards the frame with no tlast emitted.
- Output register: M_AXIS is a single register stage.
  - It loads when (!M_AXIS_tvalid || M_AXIS_tready).
  - tdata, tkeep and tlast are held stable while tvalid=1 and tready=0.
- Header byte order on the wire: Dest[47:40]..Dest[7:0], Src[47:40]..Src[7:0], Link_Type[15:8], Link_Type[7:0], SyncWord[15:8], SyncWord[7:0].
- Header inputs are latched in IDLE on the cycle S_AXIS_tvalid is first seen. Input changes after that do not affect the frame in flight.
- Byte counter pb: 14-bit count of payload bytes emitted, including pad bytes.
- State machine:
  - IDLE: S_AXIS_tready=0. When S_AXIS_tvalid=1, latch the header fields, set pb=0, go to HDR.
  - HDR: emit HDR_BEATS beats with full tkeep and tlast=0. S_AXIS_tready=0. After the last header beat loads, go to PAY.
  - PAY: S_AXIS_tready = (!M_AXIS_tvalid || M_AXIS_tready). Each accepted beat is copied to the output register (latency 1 cycle) and pb increases by popcount(tkeep).
  - Padding required: an accepted tlast beat with Enable_Padding=1 and 16+pb_new < MIN_FRAME.
    - Empty upper lanes of that beat are filled with 0x00 and tkeep is set to all ones, capped so the frame reaches exactly MIN_FRAME bytes.
    - Output tlast=0, then go to PAD.
  - Otherwise an accepted tlast beat gives output tlast=1, frame_count+1, go to IDLE.
  - Oversize: an accepted non-tlast beat makes pb_new ≥ MAX_PAYLOAD.
    - Output that beat with tkeep trimmed so pb=MAX_PAYLOAD exactly, tlast=1.
    - Pulse oversize_pulse and increment frame_count.
    - Go to DROP, or to IDLE if pb_new == MAX_PAYLOAD and tlast=1 (that case is not an oversize).
  - PAD: emit zero beats, each full or partial so the frame ends at exactly MIN_FRAME bytes. The final pad beat has tlast=1 and increments frame_count; then go to IDLE. S_AXIS_tready=0.
  - DROP: S_AXIS_tready=1 and input beats are discarded. Go to IDLE on an accepted tlast. Nothing is output.
- busy = (state != IDLE) || M_AXIS_tvalid.
- A new frame may start in IDLE on the cycle after the previous tlast beat loads; there are no idle gap beats.

Test Plan:
1. DATA_WIDTH=64, Dest=0x0A0B0C0D0E0F, Src=0x112233445566, Link_Type=0x88B5, SyncWord=0xEB90, 3 full payload beats, tready=1 -> 5 out beats; beat0 tdata=0x2211_0F0E0D0C0B0A; beat1=0x90EB_B588_66554433; frame 40 bytes, no padding since 40 < 60 only with padding on, here Enable_Padding=0; frame_count=1.
2. Same, Enable_Padding=1, 10-byte payload (beat tkeep 0xFF, then 0x03 tlast) -> 8 out beats; beat3 tkeep=0xFF with lanes 2..7 = 0; beats 4..6 tkeep=0xFF all zero; beat7 tkeep=0x0F, tlast=1; total 60 bytes.
3. MAX_PAYLOAD=20, 5 full input beats -> out payload beats tkeep 0xFF, 0xFF, 0x0F (tlast); oversize_pulse once; remaining 2 input beats accepted and dropped; next frame starts clean.
4. Random M_AXIS_tready (50%) with scenario 1 -> output byte sequence identical; tdata stable while stalled; no input beat lost or duplicated.
5. DATA_WIDTH=128 and DATA_WIDTH=32, 2-beat payload -> HDR_BEATS = 1 and 4 respectively; header bytes match scenario 1 order.
6. ARESETN low during PAY beat 2 -> all outputs at reset values immediately; the next frame after release is correct; frame_count=0.

Source files
------------

// File: rtl/eth_frame_former_v2.sv
// Ethernet II frame former: prepends a 16-byte header (Dst MAC, Src MAC,
// EtherType, SyncWord) to an AXI-Stream payload, with optional zero padding
// to MIN_FRAME bytes and truncate-and-drop of payloads beyond MAX_PAYLOAD.
// Ports: ACLK/ARESETN (async active-low); S_AXIS_* payload in; M_AXIS_* frame
// out (one register stage); header fields and Enable_Padding; frame_count,
// oversize_pulse and busy status outputs.
module eth_frame_former_v2 #(
    parameter int DATA_WIDTH  = 64,
    parameter int MAX_PAYLOAD = 1498,
    parameter int MIN_FRAME   = 60
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [DATA_WIDTH-1:0]   S_AXIS_tdata,
    input  logic [DATA_WIDTH/8-1:0] S_AXIS_tkeep,
    input  logic                    S_AXIS_tvalid,
    input  logic                    S_AXIS_tlast,
    output logic                    S_AXIS_tready,
    output logic [DATA_WIDTH-1:0]   M_AXIS_tdata,
    output logic [DATA_WIDTH/8-1:0] M_AXIS_tkeep,
    output logic                    M_AXIS_tvalid,
    output logic                    M_AXIS_tlast,
    input  logic                    M_AXIS_tready,
    input  logic [47:0]             Destination_Address,
    input  logic [47:0]             Source_Address,
    input  logic [15:0]             Link_Type,
    input  logic [15:0]             SyncWord,
    input  logic                    Enable_Padding,
    output logic [15:0]             frame_count,
    output logic                    oversize_pulse,
    output logic                    busy
);

    localparam int KW        = DATA_WIDTH / 8;
    localparam int HDR_BEATS = 128 / DATA_WIDTH;
    // Payload bytes (including pad) needed to reach the minimum frame.
    localparam int PAD_BYTES = MIN_FRAME - 16;

    typedef enum logic [2:0] {IDLE, HDR, PAY, PAD, DROP} state_t;

    state_t                state_q, state_d;
    logic [127:0]          hdr_q, hdr_d, hdr_in;
    logic [1:0]            hbeat_q, hbeat_d;
    logic [13:0]           pb_q, pb_d;
    logic [15:0]           fc_q, fc_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d, hdr_beat;
    logic [KW-1:0]         tkeep_q, tkeep_d, okeep;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic                  ld;
    int                    pbn, room, fill;

    function automatic logic [KW-1:0] lanes(input int n);
        logic [KW-1:0] m;
        for (int i = 0; i < KW; i++) m[i] = (i < n);
        return m;
    endfunction

    function automatic int popcnt(input logic [KW-1:0] k);
        int n;
        n = 0;
        for (int i = 0; i < KW; i++) n = n + (k[i] ? 1 : 0);
        return n;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] bytemask(input logic [KW-1:0] k);
        logic [DATA_WIDTH-1:0] m;
        for (int i = 0; i < KW; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    // Header packed so that wire byte i sits at bits [8i+7:8i].
    always_comb begin
        hdr_in = '0;
        for (int i = 0; i < 6; i++) begin
            hdr_in[8*i +: 8]      = Destination_Address[47-8*i -: 8];
            hdr_in[48+8*i +: 8]   = Source_Address[47-8*i -: 8];
        end
        hdr_in[103:96]  = Link_Type[15:8];
        hdr_in[111:104] = Link_Type[7:0];
        hdr_in[119:112] = SyncWord[15:8];
        hdr_in[127:120] = SyncWord[7:0];
    end

    always_comb begin
        hdr_beat = '0;
        for (int b = 0; b < HDR_BEATS; b++)
            if (hbeat_q == 2'(b)) hdr_beat = hdr_q[b*DATA_WIDTH +: DATA_WIDTH];
    end

    assign ld = !tvalid_q || M_AXIS_tready;

    always_comb begin
        state_d       = state_q;
        hdr_d         = hdr_q;
        hbeat_d       = hbeat_q;
        pb_d          = pb_q;
        fc_d          = fc_q;
        ovf_d         = 1'b0;
        tdata_d       = tdata_q;
        tkeep_d       = tkeep_q;
        tvalid_d      = tvalid_q;
        tlast_d       = tlast_q;
        S_AXIS_tready = 1'b0;
        okeep         = '0;
        pbn           = 0;
        room          = 0;
        fill          = 0;
        if (ld) tvalid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (S_AXIS_tvalid) begin
                    hdr_d   = hdr_in;
                    pb_d    = '0;
                    hbeat_d = '0;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (ld) begin
                    tdata_d  = hdr_beat;
                    tkeep_d  = '1;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    hbeat_d  = hbeat_q + 2'd1;
                    if (hbeat_q == 2'(HDR_BEATS - 1)) state_d = PAY;
                end
            end
            PAY: begin
                S_AXIS_tready = ld;
                if (S_AXIS_tvalid && ld) begin
                    pbn      = int'(pb_q) + popcnt(S_AXIS_tkeep);
                    room     = MAX_PAYLOAD - int'(pb_q);
                    okeep    = S_AXIS_tkeep;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    if (pbn > MAX_PAYLOAD ||
                        (pbn == MAX_PAYLOAD && !S_AXIS_tlast)) begin
                        // Truncate: close the frame at exactly MAX_PAYLOAD.
                        okeep   = lanes(room);
                        tlast_d = 1'b1;
                        ovf_d   = 1'b1;
                        fc_d    = fc_q + 16'd1;
                        pb_d    = 14'(MAX_PAYLOAD);
                        state_d = S_AXIS_tlast ? IDLE : DROP;
                    end else if (S_AXIS_tlast && Enable_Padding &&
                                 pbn < PAD_BYTES) begin
                        // Short frame: zero-fill the upper lanes of this beat.
                        fill = PAD_BYTES - int'(pb_q);
                        if (fill > KW) fill = KW;
                        okeep = lanes(fill);
                        pb_d  = pb_q + 14'(fill);
                        if (int'(pb_q) + fill >= PAD_BYTES) begin
                            tlast_d = 1'b1;
                            fc_d    = fc_q + 16'd1;
                            state_d = IDLE;
                        end else begin
                            state_d = PAD;
                        end
                    end else begin
                        pb_d = 14'(pbn);
                        if (S_AXIS_tlast) begin
                            tlast_d = 1'b1;
                            fc_d    = fc_q + 16'd1;
                            state_d = IDLE;
                        end
                    end
                    tkeep_d = okeep;
                    tdata_d = S_AXIS_tdata & bytemask(S_AXIS_tkeep & okeep);
                end
            end
            PAD: begin
                if (ld) begin
                    fill = PAD_BYTES - int'(pb_q);
                    if (fill > KW) fill = KW;
                    tdata_d  = '0;
                    tkeep_d  = lanes(fill);
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    pb_d     = pb_q + 14'(fill);
                    if (int'(pb_q) + fill >= PAD_BYTES) begin
                        tlast_d = 1'b1;
                        fc_d    = fc_q + 16'd1;
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                S_AXIS_tready = 1'b1;
                if (S_AXIS_tvalid && S_AXIS_tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= IDLE;
            hdr_q    <= '0;
            hbeat_q  <= '0;
            pb_q     <= '0;
            fc_q     <= '0;
            ovf_q    <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hdr_q    <= hdr_d;
            hbeat_q  <= hbeat_d;
            pb_q     <= pb_d;
            fc_q     <= fc_d;
            ovf_q    <= ovf_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

    assign M_AXIS_tdata   = tdata_q;
    assign M_AXIS_tkeep   = tkeep_q;
    assign M_AXIS_tvalid  = tvalid_q;
    assign M_AXIS_tlast   = tlast_q;
    assign frame_count    = fc_q;
    assign oversize_pulse = ovf_q;
    assign busy           = (state_q != IDLE) || tvalid_q;

endmodule

// File: tb/tb_eth_frame_former_v2.sv
// Directed bench for eth_frame_former_v2: four instances (64-bit, 64-bit with
// MAX_PAYLOAD=20, 128-bit, 32-bit) share stimulus; beats are captured per DUT.
module tb_eth_frame_former_v2;

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] s_data = '0;
    logic [15:0]  s_keep = '0;
    logic         s_valid = 1'b0;
    logic         s_last = 1'b0;
    int           sel = 0;
    logic         m_ready = 1'b1;
    bit           rand_en = 1'b0;
    logic [47:0]  dst, src;
    logic [15:0]  lt, sw;
    logic         pad_en;
    int           tests = 0;
    int           fails = 0;
    int           ovf_b_cnt = 0;
    int           stall_viol = 0;

    logic         a_rdy, a_v, a_l, a_o, a_b;
    logic [63:0]  a_d;
    logic [7:0]   a_k;
    logic [15:0]  a_fc;
    logic         b_rdy, b_v, b_l, b_o, b_b;
    logic [63:0]  b_d;
    logic [7:0]   b_k;
    logic [15:0]  b_fc;
    logic         c_rdy, c_v, c_l, c_o, c_b;
    logic [127:0] c_d;
    logic [15:0]  c_k;
    logic [15:0]  c_fc;
    logic         d_rdy, d_v, d_l, d_o, d_b;
    logic [31:0]  d_d;
    logic [3:0]   d_k;
    logic [15:0]  d_fc;

    beat_t qa[$], qb[$], qc[$], qd[$];

    always #5 clk = ~clk;

    eth_frame_former_v2 #(.DATA_WIDTH(64)) u_a (
        .ACLK(clk), .ARESETN(rst_n),
        .S_AXIS_tdata(s_data[63:0]), .S_AXIS_tkeep(s_keep[7:0]),
        .S_AXIS_tvalid(s_valid && (sel == 0)), .S_AXIS_tlast(s_last),
        .S_AXIS_tready(a_rdy),
        .M_AXIS_tdata(a_d), .M_AXIS_tkeep(a_k), .M_AXIS_tvalid(a_v),
        .M_AXIS_tlast(a_l), .M_AXIS_tready(m_ready),
        .Destination_Address(dst), .Source_Address(src),
        .Link_Type(lt), .SyncWord(sw), .Enable_Padding(pad_en),
        .frame_count(a_fc), .oversize_pulse(a_o), .busy(a_b)
    );

    eth_frame_former_v2 #(.DATA_WIDTH(64), .MAX_PAYLOAD(20)) u_b (
        .ACLK(clk), .ARESETN(rst_n),
        .S_AXIS_tdata(s_data[63:0]), .S_AXIS_tkeep(s_keep[7:0]),
        .S_AXIS_tvalid(s_valid && (sel == 1)), .S_AXIS_tlast(s_last),
        .S_AXIS_tready(b_rdy),
        .M_AXIS_tdata(b_d), .M_AXIS_tkeep(b_k), .M_AXIS_tvalid(b_v),
        .M_AXIS_tlast(b_l), .M_AXIS_tready(m_ready),
        .Destination_Address(dst), .Source_Address(src),
        .Link_Type(lt), .SyncWord(sw), .Enable_Padding(pad_en),
        .frame_count(b_fc), .oversize_pulse(b_o), .busy(b_b)
    );

    eth_frame_former_v2 #(.DATA_WIDTH(128)) u_c (
        .ACLK(clk), .ARESETN(rst_n),
        .S_AXIS_tdata(s_data), .S_AXIS_tkeep(s_keep),
        .S_AXIS_tvalid(s_valid && (sel == 2)), .S_AXIS_tlast(s_last),
        .S_AXIS_tready(c_rdy),
        .M_AXIS_tdata(c_d), .M_AXIS_tkeep(c_k), .M_AXIS_tvalid(c_v),
        .M_AXIS_tlast(c_l), .M_AXIS_tready(m_ready),
        .Destination_Address(dst), .Source_Address(src),
        .Link_Type(lt), .SyncWord(sw), .Enable_Padding(pad_en),
        .frame_count(c_fc), .oversize_pulse(c_o), .busy(c_b)
    );

    eth_frame_former_v2 #(.DATA_WIDTH(32)) u_d (
        .ACLK(clk), .ARESETN(rst_n),
        .S_AXIS_tdata(s_data[31:0]), .S_AXIS_tkeep(s_keep[3:0]),
        .S_AXIS_tvalid(s_valid && (sel == 3)), .S_AXIS_tlast(s_last),
        .S_AXIS_tready(d_rdy),
        .M_AXIS_tdata(d_d), .M_AXIS_tkeep(d_k), .M_AXIS_tvalid(d_v),
        .M_AXIS_tlast(d_l), .M_AXIS_tready(m_ready),
        .Destination_Address(dst), .Source_Address(src),
        .Link_Type(lt), .SyncWord(sw), .Enable_Padding(pad_en),
        .frame_count(d_fc), .oversize_pulse(d_o), .busy(d_b)
    );

    always @(posedge clk) begin
        #2;
        m_ready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (a_v && m_ready) qa.push_back({128'(a_d), 16'(a_k), a_l});
        if (b_v && m_ready) qb.push_back({128'(b_d), 16'(b_k), b_l});
        if (c_v && m_ready) qc.push_back({c_d, c_k, c_l});
        if (d_v && m_ready) qd.push_back({128'(d_d), 16'(d_k), d_l});
        if (b_o) ovf_b_cnt++;
    end

    logic [63:0] hold_d;
    logic [7:0]  hold_k;
    logic        hold_l;
    logic        hold_on = 1'b0;
    always @(negedge clk) begin
        if (hold_on && (!a_v || a_d != hold_d || a_k != hold_k || a_l != hold_l))
            stall_viol++;
        hold_on = a_v && !m_ready;
        hold_d  = a_d;
        hold_k  = a_k;
        hold_l  = a_l;
    end

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int dut);
        case (dut)
            0: return qa.size();
            1: return qb.size();
            2: return qc.size();
            default: return qd.size();
        endcase
    endfunction

    function automatic logic busy_of(input int dut);
        case (dut)
            0: return a_b;
            1: return b_b;
            2: return c_b;
            default: return d_b;
        endcase
    endfunction

    function automatic logic rdy_of(input int dut);
        case (dut)
            0: return a_rdy;
            1: return b_rdy;
            2: return c_rdy;
            default: return d_rdy;
        endcase
    endfunction

    function automatic beat_t getb(input int dut, input int i);
        beat_t b;
        b = '0;
        case (dut)
            0: if (i < qa.size()) b = qa[i];
            1: if (i < qb.size()) b = qb[i];
            2: if (i < qc.size()) b = qc[i];
            default: if (i < qd.size()) b = qd[i];
        endcase
        return b;
    endfunction

    // Called and returns at a negedge; holds the beat until it is accepted.
    task automatic send(input int dut, input logic [127:0] d,
                        input logic [15:0] k, input logic l);
        logic ok;
        ok      = 1'b0;
        sel     = dut;
        s_data  = d;
        s_keep  = k;
        s_last  = l;
        s_valid = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            #1;
            if (rdy_of(dut)) ok = 1'b1;
            @(negedge clk);
        end
        s_valid = 1'b0;
        if (!ok) check("send_accept", 128'(ok), 128'(1));
    endtask

    task automatic drain(input int dut, input int n, input string tag);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (qsize(dut) >= n && !busy_of(dut)) break;
        end
        repeat (3) @(negedge clk);
        check(tag, 128'(qsize(dut)), 128'(n));
    endtask

    task automatic frame1();
        send(0, 128'(64'h0706050403020100), 16'h00FF, 1'b0);
        send(0, 128'(64'h0F0E0D0C0B0A0908), 16'h00FF, 1'b0);
        send(0, 128'(64'h1716151413121110), 16'h00FF, 1'b1);
    endtask

    localparam logic [127:0] H0  = 128'h2211_0F0E0D0C0B0A;
    localparam logic [127:0] H1  = 128'h90EB_B588_66554433;
    localparam logic [127:0] H16 = 128'h90EBB58866554433_22110F0E0D0C0B0A;

    initial begin
        beat_t b;
        dst    = 48'h0A0B0C0D0E0F;
        src    = 48'h112233445566;
        lt     = 16'h88B5;
        sw     = 16'hEB90;
        pad_en = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tvalid", 128'(a_v), 128'(0));
        check("rst_tdata", 128'(a_d), 128'(0));
        check("rst_tkeep", 128'(a_k), 128'(0));
        check("rst_tready", 128'(a_rdy), 128'(0));
        check("rst_fc", 128'(a_fc), 128'(0));
        check("rst_busy", 128'(a_b), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // 1: 24-byte payload, no padding; header change mid-frame ignored
        send(0, 128'(64'h0706050403020100), 16'h00FF, 1'b0);
        dst = 48'hFFFFFFFFFFFF;
        send(0, 128'(64'h0F0E0D0C0B0A0908), 16'h00FF, 1'b0);
        send(0, 128'(64'h1716151413121110), 16'h00FF, 1'b1);
        drain(0, 5, "t1_nbeats");
        dst = 48'h0A0B0C0D0E0F;
        b = getb(0, 0); check("t1_hdr0", b.d, H0);
        check("t1_hdr0_keep", 128'(b.k), 128'(16'h00FF));
        b = getb(0, 1); check("t1_hdr1", b.d, H1);
        b = getb(0, 3); check("t1_b3_last", 128'(b.l), 128'(0));
        b = getb(0, 4); check("t1_b4_data", b.d, 128'(64'h1716151413121110));
        check("t1_b4_last", 128'(b.l), 128'(1));
        check("t1_fc", 128'(a_fc), 128'(1));

        // 2: 10-byte payload padded to 60 bytes
        qa.delete();
        pad_en = 1'b1;
        send(0, 128'(64'hA7A6A5A4A3A2A1A0), 16'h00FF, 1'b0);
        send(0, 128'(64'hFFFFFFFFFFFFBBAA), 16'h0003, 1'b1);
        drain(0, 8, "t2_nbeats");
        pad_en = 1'b0;
        b = getb(0, 3); check("t2_b3_data", b.d, 128'h0000BBAA);
        check("t2_b3_keep", 128'(b.k), 128'(16'h00FF));
        check("t2_b3_last", 128'(b.l), 128'(0));
        b = getb(0, 5); check("t2_b5_data", b.d, 128'(0));
        check("t2_b5_keep", 128'(b.k), 128'(16'h00FF));
        b = getb(0, 7); check("t2_b7_keep", 128'(b.k), 128'(16'h000F));
        check("t2_b7_last", 128'(b.l), 128'(1));
        check("t2_fc", 128'(a_fc), 128'(2));

        // 3: MAX_PAYLOAD=20, 40-byte payload truncated then dropped
        for (int i = 0; i < 5; i++)
            send(1, 128'(64'h8877665544332211), 16'h00FF, i == 4);
        drain(1, 5, "t3_nbeats");
        b = getb(1, 3); check("t3_b3_keep", 128'(b.k), 128'(16'h00FF));
        check("t3_b3_last", 128'(b.l), 128'(0));
        b = getb(1, 4); check("t3_b4_keep", 128'(b.k), 128'(16'h000F));
        check("t3_b4_last", 128'(b.l), 128'(1));
        check("t3_b4_data", b.d, 128'h44332211);
        check("t3_ovf_cnt", 128'(ovf_b_cnt), 128'(1));
        check("t3_fc", 128'(b_fc), 128'(1));
        qb.delete();
        send(1, 128'(64'h0000000000CCBBAA), 16'h0007, 1'b1);
        drain(1, 3, "t3_next_nbeats");
        b = getb(1, 0); check("t3_next_hdr0", b.d, H0);
        b = getb(1, 2); check("t3_next_data", b.d, 128'hCCBBAA);
        check("t3_next_keep", 128'(b.k), 128'(16'h0007));
        check("t3_next_last", 128'(b.l), 128'(1));
        // exactly MAX_PAYLOAD bytes on tlast is not an oversize
        qb.delete();
        send(1, 128'(64'h1111111111111111), 16'h00FF, 1'b0);
        send(1, 128'(64'h2222222222222222), 16'h00FF, 1'b0);
        send(1, 128'(64'h0000000033333333), 16'h000F, 1'b1);
        drain(1, 5, "t3_exact_nbeats");
        b = getb(1, 4); check("t3_exact_keep", 128'(b.k), 128'(16'h000F));
        check("t3_exact_last", 128'(b.l), 128'(1));
        check("t3_exact_ovf", 128'(ovf_b_cnt), 128'(1));
        check("t3_exact_fc", 128'(b_fc), 128'(3));

        // 4: scenario 1 with random downstream back-pressure
        qa.delete();
        rand_en = 1'b1;
        frame1();
        drain(0, 5, "t4_nbeats");
        rand_en = 1'b0;
        b = getb(0, 0); check("t4_hdr0", b.d, H0);
        b = getb(0, 1); check("t4_hdr1", b.d, H1);
        b = getb(0, 2); check("t4_b2", b.d, 128'(64'h0706050403020100));
        b = getb(0, 3); check("t4_b3", b.d, 128'(64'h0F0E0D0C0B0A0908));
        b = getb(0, 4); check("t4_b4", b.d, 128'(64'h1716151413121110));
        check("t4_b4_last", 128'(b.l), 128'(1));
        check("t4_stall_stable", 128'(stall_viol), 128'(0));
        check("t4_fc", 128'(a_fc), 128'(3));

        // 5: 128-bit and 32-bit widths
        send(2, 128'h1F1E1D1C1B1A19181716151413121110, 16'hFFFF, 1'b0);
        send(2, 128'h2F2E2D2C2B2A29282726252423222120, 16'hFFFF, 1'b1);
        drain(2, 3, "t5w128_nbeats");
        b = getb(2, 0); check("t5w128_hdr", b.d, H16);
        check("t5w128_keep", 128'(b.k), 128'(16'hFFFF));
        b = getb(2, 2); check("t5w128_last", 128'(b.l), 128'(1));
        send(3, 128'(32'h03020100), 16'h000F, 1'b0);
        send(3, 128'(32'h07060504), 16'h000F, 1'b1);
        drain(3, 6, "t5w32_nbeats");
        b = getb(3, 0); check("t5w32_h0", b.d, 128'h0D0C0B0A);
        b = getb(3, 1); check("t5w32_h1", b.d, 128'h22110F0E);
        b = getb(3, 2); check("t5w32_h2", b.d, 128'h66554433);
        b = getb(3, 3); check("t5w32_h3", b.d, 128'h90EBB588);
        b = getb(3, 4); check("t5w32_p0", b.d, 128'h03020100);
        b = getb(3, 5); check("t5w32_last", 128'(b.l), 128'(1));
        check("t5w32_keep", 128'(b.k), 128'(16'h000F));

        // 6: reset in the middle of the payload
        qa.delete();
        send(0, 128'(64'h0706050403020100), 16'h00FF, 1'b0);
        send(0, 128'(64'h0F0E0D0C0B0A0908), 16'h00FF, 1'b0);
        sel = 0;
        s_data = 128'(64'h1716151413121110);
        s_keep = 16'h00FF;
        s_last = 1'b1;
        s_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("t6_tvalid", 128'(a_v), 128'(0));
        check("t6_tdata", 128'(a_d), 128'(0));
        check("t6_tlast", 128'(a_l), 128'(0));
        check("t6_tready", 128'(a_rdy), 128'(0));
        check("t6_busy", 128'(a_b), 128'(0));
        check("t6_fc", 128'(a_fc), 128'(0));
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        qa.delete();
        frame1();
        drain(0, 5, "t6_nbeats");
        b = getb(0, 0); check("t6_hdr0", b.d, H0);
        b = getb(0, 4); check("t6_b4_data", b.d, 128'(64'h1716151413121110));
        check("t6_b4_last", 128'(b.l), 128'(1));
        check("t6_fc_after", 128'(a_fc), 128'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
